// File: rtl/pipe_skid_if.sv
// Valid/ready handshake bundle for pipe_skid: upstream request side and downstream response side.
// The slave modport is the buffer's view; the master modport is the surrounding stages' view.
interface pipe_skid_if #(
    parameter int DW = 32
);
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic [1:0]    o_cnt;

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_cnt
    );

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_cnt
    );
endinterface

// File: rtl/pipe_skid.sv
// Two-entry valid/ready skid buffer: a main (head) register plus a skid register.
// i_ready, o_valid and o_data come straight from flops, so o_ready has no combinational path upstream.
module pipe_skid #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    pipe_skid_if.slave  bus
);
    // Encoding chosen so bit 0 is main_v and bit 1 is skid_v; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_main_q;
    logic [DW-1:0] r_skid_q;

    logic w_main_v;
    logic w_skid_v;
    logic w_in;
    logic w_out;
    logic w_ld_main;
    logic w_main_from_skid;
    logic w_ld_skid;

    assign w_main_v = r_state[0];
    assign w_skid_v = r_state[1];
    assign w_in     = bus.i_valid & ~w_skid_v;
    assign w_out    = w_main_v & bus.o_ready;

    assign bus.i_ready = ~w_skid_v;
    assign bus.o_valid = w_main_v;
    assign bus.o_data  = r_main_q;
    assign bus.o_cnt   = {1'b0, w_main_v} + {1'b0, w_skid_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ld_main        = 1'b0;
        w_main_from_skid = 1'b0;
        w_ld_skid        = 1'b0;
        if (flush) begin
            // Flush wins outright: nothing is captured, data registers keep their contents.
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in) begin
                        w_ld_main   = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in && w_out) begin
                        w_ld_main = 1'b1;
                    end else if (w_in) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_out) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out) begin
                        w_ld_main        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_q <= RESET_VAL;
            r_skid_q <= RESET_VAL;
        end else begin
            if (w_ld_main) r_main_q <= w_main_from_skid ? r_skid_q : bus.i_data;
            if (w_ld_skid) r_skid_q <= bus.i_data;
        end
    end
endmodule

// File: tb/tb_pipe_skid.sv
// Bench for pipe_skid: directed vector table, async reset sequence, and a randomized run
// scored against a two-slot FIFO queue model.
module tb_pipe_skid;
    logic clk;
    logic rst_n;
    logic flush;
    logic flush_b;

    pipe_skid_if #(.DW(32)) ifa ();
    pipe_skid_if #(.DW(32)) ifb ();

    pipe_skid #(.DW(32), .RESET_VAL(32'h0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (ifa)
    );

    pipe_skid #(.DW(32), .RESET_VAL(32'hDEAD_BEEF)) u_dut_db (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_b),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        ev;
        logic [31:0] ed;
        logic        cd;
        logic        er;
        logic [1:0]  ec;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mq[$];
    int          n_pass = 0;
    int          n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic add(input logic v, input logic [31:0] d, input logic r, input logic f,
                       input logic ev, input logic [31:0] ed, input logic cd,
                       input logic er, input logic [1:0] ec);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.f = f;
        x.ev = ev; x.ed = ed; x.cd = cd; x.er = er; x.ec = ec;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        ifa.i_valid = v;
        ifa.i_data  = d;
        ifa.o_ready = r;
        flush       = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_db_reset(input string tag);
        chk({tag, "_db_odata"},  ifb.o_data, 32'hDEAD_BEEF);
        chk({tag, "_db_ovalid"}, {31'b0, ifb.o_valid}, 32'd0);
        chk({tag, "_db_cnt"},    {30'b0, ifb.o_cnt}, 32'd0);
        chk({tag, "_db_iready"}, {31'b0, ifb.i_ready}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        flush_b = 1'b0;
        ifb.i_valid = 1'b0;
        ifb.i_data  = '0;
        ifb.o_ready = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // Rows: inputs applied this cycle; expectations are the registered outputs seen before the edge.
        // Streaming 0x1..0x10 with o_ready held high.
        add(1, 32'h1, 1, 0, 0, 32'h0, 0, 1, 0);
        for (int i = 1; i < 16; i++) add(1, 32'(i + 1), 1, 0, 1, 32'(i), 1, 1, 1);
        add(0, 32'h0, 1, 0, 1, 32'h10, 1, 1, 1);
        add(0, 32'h0, 1, 0, 0, 32'h10, 1, 1, 0);
        // Backpressure: A, B accepted, C held upstream until space opens.
        add(1, 32'hA, 0, 0, 0, 32'h0, 0, 1, 0);
        add(1, 32'hB, 0, 0, 1, 32'hA, 1, 1, 1);
        add(1, 32'hC, 0, 0, 1, 32'hA, 1, 0, 2);
        add(1, 32'hC, 0, 0, 1, 32'hA, 1, 0, 2);
        add(1, 32'hC, 1, 0, 1, 32'hA, 1, 0, 2);
        add(1, 32'hC, 1, 0, 1, 32'hB, 1, 1, 1);
        add(0, 32'h0, 1, 0, 1, 32'hC, 1, 1, 1);
        add(0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 0);
        // Simultaneous in/out while holding 0x5.
        add(1, 32'h5, 0, 0, 0, 32'h0, 0, 1, 0);
        add(1, 32'h6, 1, 0, 1, 32'h5, 1, 1, 1);
        add(0, 32'h0, 0, 0, 1, 32'h6, 1, 1, 1);
        // Flush while FULL with i_valid high.
        add(1, 32'h7, 0, 0, 1, 32'h6, 1, 1, 1);
        add(1, 32'h8, 0, 1, 1, 32'h6, 1, 0, 2);
        add(0, 32'h0, 1, 0, 0, 32'h6, 1, 1, 0);
        // Flush in ONE with an input that would otherwise be taken.
        add(1, 32'h9, 0, 0, 0, 32'h0, 0, 1, 0);
        add(1, 32'hA5, 1, 1, 1, 32'h9, 1, 1, 1);
        add(0, 32'h0, 1, 0, 0, 32'h9, 1, 1, 0);
        add(1, 32'h11, 1, 0, 0, 32'h0, 0, 1, 0);
        add(0, 32'h0, 1, 0, 1, 32'h11, 1, 1, 1);
        add(0, 32'h0, 0, 0, 0, 32'h11, 1, 1, 0);

        // Reset held, then idle.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ovalid", {31'b0, ifa.o_valid}, 32'd0);
        chk("rst_iready", {31'b0, ifa.i_ready}, 32'd1);
        chk("rst_cnt",    {30'b0, ifa.o_cnt}, 32'd0);
        chk("rst_odata",  ifa.o_data, 32'h0);
        chk_db_reset("rst");
        rst_n = 1'b1;
        repeat (3) tick();
        chk("idle_ovalid", {31'b0, ifa.o_valid}, 32'd0);
        chk("idle_odata",  ifa.o_data, 32'h0);
        chk_db_reset("idle");

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].d, tbl[k].r, tbl[k].f);
            #1;
            chk($sformatf("vec%0d_ovalid", k), {31'b0, ifa.o_valid}, {31'b0, tbl[k].ev});
            chk($sformatf("vec%0d_iready", k), {31'b0, ifa.i_ready}, {31'b0, tbl[k].er});
            chk($sformatf("vec%0d_cnt", k),    {30'b0, ifa.o_cnt},   {30'b0, tbl[k].ec});
            if (tbl[k].cd) chk($sformatf("vec%0d_odata", k), ifa.o_data, tbl[k].ed);
            tick();
        end

        // Async reset while FULL, asserted between clock edges.
        drive(1, 32'h21, 0, 0); tick();
        drive(1, 32'h22, 0, 0); tick();
        drive(0, 32'h0, 0, 0);
        #1;
        chk("pre_arst_cnt", {30'b0, ifa.o_cnt}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ovalid", {31'b0, ifa.o_valid}, 32'd0);
        chk("arst_cnt",    {30'b0, ifa.o_cnt}, 32'd0);
        chk("arst_iready", {31'b0, ifa.i_ready}, 32'd1);
        chk("arst_odata",  ifa.o_data, 32'h0);
        chk_db_reset("arst");
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        drive(1, 32'h77, 1, 0);
        #1;
        chk("post_rst_ovalid", {31'b0, ifa.o_valid}, 32'd0);
        tick();
        drive(0, 32'h0, 1, 0);
        #1;
        chk("post_rst_ovalid1", {31'b0, ifa.o_valid}, 32'd1);
        chk("post_rst_odata",   ifa.o_data, 32'h77);
        tick();
        #1;
        chk("post_rst_drain", {31'b0, ifa.o_valid}, 32'd0);

        // Randomized run against a queue model of capacity 2.
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            logic        v, r, f, acc, pop;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 63) == 0);
            d = $urandom;
            drive(v, d, r, f);
            #1;
            chk("rnd_ovalid", {31'b0, ifa.o_valid}, {31'b0, mq.size() > 0});
            chk("rnd_iready", {31'b0, ifa.i_ready}, {31'b0, mq.size() < 2});
            chk("rnd_cnt",    {30'b0, ifa.o_cnt},   32'(mq.size()));
            if (mq.size() > 0) chk("rnd_odata", ifa.o_data, mq[0]);
            // i_ready must not react to o_ready within the cycle.
            ifa.o_ready = ~r;
            #1;
            chk("rnd_iready_comb", {31'b0, ifa.i_ready}, {31'b0, mq.size() < 2});
            ifa.o_ready = r;
            acc = v && (mq.size() < 2);
            pop = r && (mq.size() > 0);
            tick();
            if (f) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(d);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
